// File: rtl/mem_port_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_pkg
// Purpose  : Shared types and constants for the unified memory port master.
//            - mem_state_t : access sequencer states.
//            - SZ_*        : request size encodings.
// Config   : MEM_SUBWORD_EN (consumed by mem_port_master)
// Revision : 1.0 - initial release
// ============================================================================
package mem_port_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } mem_state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

endpackage
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ============================================================================
// Module   : mem_lane_align
// Purpose  : Purely combinational lane handling for sub-word accesses.
//            Extracts and sign/zero-extends load data from a memory word,
//            and merges store data into a previously read memory word.
// Ports    : size        in  2   request size (SZ_BYTE/SZ_HALF/other=word)
//            is_unsigned in  1   zero-extend sub-word loads when high
//            addr_lo     in  2   byte offset within the word
//            word        in  32  word read from memory
//            wdata       in  32  right-aligned store data
//            load_data   out 32  aligned, extended load result
//            store_data  out 32  word to write back to memory
// Config   : only instantiated when MEM_SUBWORD_EN is defined
// Revision : 1.0 - initial release
// ============================================================================
module mem_lane_align
  import mem_port_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_data
);

  logic [4:0]  sh_byte;
  logic [4:0]  sh_half;
  logic [31:0] byte_src;
  logic [31:0] half_src;

  // Bit offsets of the addressed byte lane and half lane.
  assign sh_byte  = {addr_lo, 3'b000};
  assign sh_half  = {addr_lo[1], 4'b0000};
  assign byte_src = word >> sh_byte;
  assign half_src = word >> sh_half;

  always_comb begin
    load_data  = word;
    store_data = wdata;
    case (size)
      SZ_BYTE: begin
        load_data  = {{24{~is_unsigned & byte_src[7]}}, byte_src[7:0]};
        store_data = (word & ~(32'h0000_00FF << sh_byte)) |
                     ({24'h0, wdata[7:0]} << sh_byte);
      end
      SZ_HALF: begin
        load_data  = {{16{~is_unsigned & half_src[15]}}, half_src[15:0]};
        store_data = (word & ~(32'h0000_FFFF << sh_half)) |
                     ({16'h0, wdata[15:0]} << sh_half);
      end
      default: begin
        load_data  = word;
        store_data = wdata;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_port_master.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_master
// Purpose  : Initiator for the unified instruction/data memory port. Accepts
//            byte-addressed load/store requests over valid/ready, issues
//            word-indexed memory accesses and returns a one-cycle response.
//            Sub-word stores are done as read-modify-write.
// Ports    : clk, rst_n (async, active low)
//            req_valid/req_ready/req_we/req_size/req_unsigned/req_addr/
//            req_wdata                    request channel
//            rsp_valid/rsp_rdata/rsp_err  response (no backpressure)
//            mem_WrEn/mem_RdEn/mem_addr/mem_WrData/mem_MemData  memory side
// Config   : MEM_SUBWORD_EN - enables byte/half loads and RMW stores; when
//            undefined every access is a word access.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_master
  import mem_port_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_WrEn,
  output logic        mem_RdEn,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_WrData,
  input  logic [31:0] mem_MemData
);

  mem_state_t  state;
  mem_state_t  state_next;
  logic        accept;
  logic        misaligned;
  logic        subword;
  logic        we_q;
  logic        err_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] word_q;
  logic [31:0] load_data;
  logic [31:0] store_data;

  assign accept = req_valid && (state == IDLE);

`ifdef MEM_SUBWORD_EN
  logic [1:0] size_q;
  logic       uns_q;

  always_comb begin
    misaligned = 1'b0;
    subword    = 1'b0;
    case (req_size)
      SZ_BYTE: subword = 1'b1;
      SZ_HALF: begin
        subword    = 1'b1;
        misaligned = req_addr[0];
      end
      default: misaligned = |req_addr[1:0];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      size_q <= SZ_WORD;
      uns_q  <= 1'b0;
    end else if (accept) begin
      size_q <= req_size;
      uns_q  <= req_unsigned;
    end
  end

  mem_lane_align u_lane_align (
    .size        (size_q),
    .is_unsigned (uns_q),
    .addr_lo     (addr_q[1:0]),
    .word        (word_q),
    .wdata       (wdata_q),
    .load_data   (load_data),
    .store_data  (store_data)
  );
`else
  // Word-only build: size/signedness are don't-care and the byte offset only
  // matters for the alignment check.
  logic unused_cfg;
  assign unused_cfg = ^{req_size, req_unsigned, addr_q[1:0]};
  assign misaligned = |req_addr[1:0];
  assign subword    = 1'b0;
  assign load_data  = word_q;
  assign store_data = wdata_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      word_q  <= 32'h0;
    end else begin
      state <= state_next;
      if (accept) begin
        we_q    <= req_we;
        err_q   <= misaligned;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      // Memory read data is combinational; capture it at the end of RD.
      if (state == RD) begin
        word_q <= mem_MemData;
      end
    end
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    mem_RdEn   = 1'b0;
    mem_WrEn   = 1'b0;
    mem_WrData = 32'h0;
    rsp_valid  = 1'b0;
    rsp_err    = 1'b0;
    rsp_rdata  = 32'h0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (accept) begin
          if (misaligned) begin
            state_next = RESP;
          end else if (!req_we || subword) begin
            // Loads and sub-word stores both need the current word first.
            state_next = RD;
          end else begin
            state_next = WR;
          end
        end
      end
      RD: begin
        mem_RdEn   = 1'b1;
        state_next = we_q ? WR : RESP;
      end
      WR: begin
        mem_WrEn   = 1'b1;
        mem_WrData = store_data;
        state_next = RESP;
      end
      RESP: begin
        rsp_valid  = 1'b1;
        rsp_err    = err_q;
        rsp_rdata  = (!we_q && !err_q) ? load_data : 32'h0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign mem_addr = {2'b00, addr_q[31:2]};

endmodule
`default_nettype wire

// File: tb/tb_mem_port_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_master
// Purpose  : Self-checking bench for mem_port_master. A 16-word memory model
//            sits on the memory port; a reference model predicts responses,
//            memory writes and latencies, and a monitor compares them.
// Config   : MEM_SUBWORD_EN selects the sub-word reference behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b10;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_WrEn;
  logic        mem_RdEn;
  logic [31:0] mem_addr;
  logic [31:0] mem_WrData;
  logic [31:0] mem_MemData;

  always #5 clk = ~clk;

  mem_port_master dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .mem_WrEn     (mem_WrEn),
    .mem_RdEn     (mem_RdEn),
    .mem_addr     (mem_addr),
    .mem_WrData   (mem_WrData),
    .mem_MemData  (mem_MemData)
  );

  // Memory under the port: combinational read, write on rising edge.
  logic [31:0] mem     [0:15];
  logic [31:0] ref_mem [0:15];
  assign mem_MemData = mem[mem_addr[3:0]];
  always @(posedge clk) if (mem_WrEn) mem[mem_addr[3:0]] <= mem_WrData;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    logic [31:0] idx;
    logic        st;
    logic [31:0] wdat;
  } exp_t;

  exp_t exp_q[$];
  int   marks[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  bit   outstanding = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: derives the outcome of a request from the access rules.
  task automatic model(input bit we, input logic [1:0] sz, input bit uns,
                       input logic [31:0] a, input logic [31:0] wd);
    exp_t        e;
    int          nb;
    int          off;
    logic [31:0] mask;
    logic [31:0] w;
    logic [31:0] v;
`ifdef MEM_SUBWORD_EN
    nb = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
`else
    nb = 4;
`endif
    off    = int'(a % 4);
    mask   = (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 32'h1);
    e.idx  = {2'b00, a[31:2]};
    e.st   = we;
    e.wdat = 32'h0;
    e.rdata = 32'h0;
    e.err  = 1'b0;
    w      = ref_mem[a[5:2]];
    if ((a % nb) != 0) begin
      e.err = 1'b1;
      e.lat = 1;
    end else if (!we) begin
      v = (w >> (8 * off)) & mask;
      if (!uns && nb < 4 && v[8*nb-1]) v = v | ~mask;
      e.rdata = v;
      e.lat   = 2;
    end else begin
      v = (w & ~(mask << (8 * off))) | ((wd & mask) << (8 * off));
      e.wdat = v;
      e.lat  = (nb == 4) ? 2 : 3;
      ref_mem[a[5:2]] = v;
    end
    exp_q.push_back(e);
  endtask

  // Drive one request and return just after its accept edge with req_valid
  // still high, so a following call queues the next request immediately.
  task automatic issue(input bit we, input logic [1:0] sz, input bit uns,
                       input logic [31:0] a, input logic [31:0] wd);
    int n;
    model(we, sz, uns, a, wd);
    req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check("accept_timeout", 32'h0, 32'h1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n;
    req_valid = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
    idle(2);
  endtask

  // Monitor: protocol invariants, memory-side checks and response scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      marks.delete();
      outstanding = 0;
    end else begin
      if (mem_RdEn && mem_WrEn) check("rd_wr_overlap", 32'h1, 32'h0);
      if (exp_q.size() != 0 && (mem_RdEn || mem_WrEn)) begin
        check("mem_addr", mem_addr, exp_q[0].idx);
        check("enable_on_err", {31'b0, exp_q[0].err}, 32'h0);
        if (mem_WrEn) begin
          check("write_on_load", {31'b0, exp_q[0].st}, 32'h1);
          check("mem_WrData", mem_WrData, exp_q[0].wdat);
        end
      end
      if (outstanding) check("ready_while_busy", {31'b0, req_ready}, 32'h0);
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", 32'h1, 32'h0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("rsp_rdata", rsp_rdata, e.rdata);
          check("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
          if (marks.size() != 0) check("latency", cyc - marks.pop_front(), e.lat);
          else check("latency_no_accept", 32'h1, 32'h0);
        end
        outstanding = 0;
      end
      if (req_valid && req_ready) begin
        marks.push_back(cyc);
        outstanding = 1;
      end
    end
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem[i]     = 32'h1111_0000 * i + 32'h0101 * i;
      ref_mem[i] = mem[i];
    end
    mem[3]     = 32'h8899_AABB;
    ref_mem[3] = 32'h8899_AABB;

    // Reset values.
    #3;
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_err", {31'b0, rsp_err}, 32'h0);
    check("rst_WrEn", {31'b0, mem_WrEn}, 32'h0);
    check("rst_RdEn", {31'b0, mem_RdEn}, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_WrData", mem_WrData, 32'h0);
    check("rst_req_ready", {31'b0, req_ready}, 32'h1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_ready", {31'b0, req_ready}, 32'h1);

    // Directed: word load, byte/half loads, misaligned word load.
    issue(1'b0, 2'b10, 1'b0, 32'h0C, 32'h0);
    idle(1);
    issue(1'b0, 2'b00, 1'b0, 32'h0E, 32'h0);
    issue(1'b0, 2'b00, 1'b1, 32'h0E, 32'h0);
    issue(1'b0, 2'b01, 1'b1, 32'h0C, 32'h0);
    idle(1);
    issue(1'b0, 2'b10, 1'b0, 32'h0D, 32'h0);
    drain();

    // Reset during the WR cycle of a word store to word 3.
    req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h0C; req_wdata = 32'hDEAD_BEEF; req_valid = 1'b1;
    @(negedge clk);
    check("rstwr_ready", {31'b0, req_ready}, 32'h1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("rstwr_WrEn_before", {31'b0, mem_WrEn}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstwr_WrEn_drop", {31'b0, mem_WrEn}, 32'h0);
    check("rstwr_ready_after", {31'b0, req_ready}, 32'h1);
    check("rstwr_no_rsp", {31'b0, rsp_valid}, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rstwr_no_rsp_late", {31'b0, rsp_valid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rstwr_mem_kept", mem[3], ref_mem[3]);
    @(posedge clk);
    #1;

    // Half store with read-modify-write, then reload the word.
    issue(1'b1, 2'b01, 1'b0, 32'h0E, 32'h0000_1234);
    idle(1);
    issue(1'b0, 2'b10, 1'b0, 32'h0C, 32'h0);
    idle(1);

    // Two requests queued with req_valid held high.
    issue(1'b0, 2'b10, 1'b0, 32'h08, 32'h0);
    issue(1'b1, 2'b00, 1'b0, 32'h09, 32'h0000_00A5);
    drain();

    // Randomized traffic.
    for (int k = 0; k < 120; k++) begin
      logic [31:0] a;
      logic [1:0]  sz;
      a  = $urandom_range(0, 63);
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b01) a[0] = 1'b0;
        else if (sz != 2'b00) a[1:0] = 2'b00;
      end
      issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
      if ($urandom_range(0, 2) != 0) idle($urandom_range(0, 3));
    end
    drain();

    for (int i = 0; i < 16; i++) check("final_mem", mem[i], ref_mem[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0x%08h expected 0x%08h", 32'h1, 32'h0);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/mem_port_master.md
# mem_port_master

Initiator side of the unified instruction/data memory port in the multicycle RISC-V core. It accepts byte-addressed load and store requests from the control unit over a valid/ready handshake. It converts each request into word-indexed accesses on the memory's `WrEn`/`RdEn`/`addr`/`WrData`/`MemData` interface, and returns aligned, extended load data with a one-cycle response pulse. Sub-word stores are performed as read-modify-write.

## Interface
No parameters; address and data widths are fixed at 32.
- `clk` in 1: single clock; memory samples writes on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: high only in IDLE; accept = `req_valid & req_ready` at a rising edge.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 half, 10 word; 11 treated as word.
- `req_unsigned` in 1: zero-extend sub-word loads when high.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned.
- `rsp_valid` out 1: one-cycle completion pulse; no backpressure.
- `rsp_rdata` out 32: load result; 0 for stores and errors.
- `rsp_err` out 1: misaligned request, valid with `rsp_valid`.
- `mem_WrEn` out 1: memory write enable.
- `mem_RdEn` out 1: memory read enable.
- `mem_addr` out 32: word index, `{2'b00, addr[31:2]}`.
- `mem_WrData` out 32: memory write data.
- `mem_MemData` in 32: combinational read data from memory.

## Operation
- States:
  - IDLE: default state.
  - RD: drives `mem_RdEn`; the word is captured at the end of the cycle.
  - WR: drives `mem_WrEn`.
  - RESP: drives `rsp_valid` high.
- On accept, latch `we`, `size`, `unsigned`, `addr`, `wdata`.
- Alignment check on accept. Misaligned means a half with `addr[0]` set, or a word with `addr[1:0] != 0`.
  - Misaligned requests go IDLE→RESP with `rsp_err=1`.
  - No memory enable is asserted for a misaligned request.
- Load: IDLE→RD→RESP.
  - Byte lane = `addr[1:0]`; half lane = `addr[1]`.
  - Extended per `req_unsigned`.
- Word store: IDLE→WR→RESP; `mem_WrData = wdata`.
- Sub-word store: IDLE→RD→WR→RESP.
  - The WR cycle writes the captured word with only the addressed byte/half lane replaced by the low bits of `wdata`.
- RESP→IDLE unconditionally.
- `mem_RdEn` and `mem_WrEn` are decoded from state and are never high together.
- `mem_addr` is held from the latched address for the whole access.

## Timing
- Reset values:
  - `rsp_valid`, `rsp_rdata`, `rsp_err`, `mem_WrEn`, `mem_RdEn`, `mem_addr`, `mem_WrData` = 0.
  - State = IDLE, so `req_ready` = 1 during and after reset.
- Latency, counted from the accept edge:
  - `rsp_valid` high in cycle 1 for errors.
  - Cycle 2 for loads and word stores.
  - Cycle 3 for sub-word stores.
- Throughput: the next request is accepted no earlier than the cycle after RESP.
- `req_valid` is ignored outside IDLE. A request held high is accepted once, at the first IDLE edge.
- Reset asserted mid-access:
  - Enables drop immediately.
  - A WR cycle interrupted before its rising edge performs no write.
  - No `rsp_valid` is produced for the aborted request.

## Configuration
- `MEM_SUBWORD_EN` defined:
  - Byte/half loads and read-modify-write stores are supported as above.
- `MEM_SUBWORD_EN` undefined:
  - `req_size` and `req_unsigned` are ignored; every access is a word access.
  - Any `addr[1:0] != 0` → `rsp_err`.
  - Stores always take IDLE→WR→RESP.
  - No lane extract/merge logic is built.

## Structure
- Package `mem_port_pkg` holds:
  - State enum `mem_state_t` (IDLE, RD, WR, RESP).
  - Size constants `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`.
- Sub-module `mem_lane_align`, purely combinational:
  - Load extract/extend.
  - Store merge.
  - Instantiated only under `MEM_SUBWORD_EN`.

## Test plan
Memory model preloaded with word 3 = 0x8899AABB.
1. Word load, addr 0x0C → `mem_addr`=3, `mem_RdEn` high in cycle 1, `rsp_valid` in cycle 2 with `rsp_rdata`=0x8899AABB and `rsp_err`=0.
2. Byte load, addr 0x0E:
   - Signed → 0xFFFFFF99.
   - Unsigned → 0x00000099.
   - Half load at 0x0C, unsigned → 0x0000AABB.
3. Half store 0x00001234 at 0x0E → RD in cycle 1, `mem_WrEn` in cycle 2 with `mem_WrData`=0x1234AABB, `rsp_valid` in cycle 3; a word reload returns 0x1234AABB.
4. Word load at 0x0D → `rsp_valid`+`rsp_err` in cycle 1, `rsp_rdata`=0; `mem_RdEn` and `mem_WrEn` never assert.
5. `rst_n` pulled low during the WR state of a word store to word 3 → `mem_WrEn` falls immediately, memory stays 0x8899AABB, no `rsp_valid`, `req_ready`=1.
6. `req_valid` held high across two queued requests → second accept occurs only on the edge after RESP; `req_ready` is low in RD/WR/RESP.
